// File: rtl/game_select_ctrl_if.sv
// Handshake between the game select controller and the main_mem ROM loader.
interface game_select_ctrl_if;
  logic [3:0] index;      // ROM slot requested from main_mem
  logic       reload;     // one-cycle load request
  logic       load_done;  // loader status, high = ROM loaded and valid

  modport master (output index, output reload, input  load_done);
  modport slave  (input  index, input  reload, output load_done);
endinterface

// File: rtl/game_select_ctrl.sv
// Select-button sequencer for the ROM loader: debounce, short/long press
// classification, game index, reload pulse and load-done tracking.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// S_BOOT      | initial ROM load after reset, NES held in reset
// S_IDLE      | game running (or last load failed), waiting for a press
// S_PRESSED   | debounced button down, measuring hold length
// S_RELOAD    | reload pulse to main_mem, index already updated
// S_WAIT_LOW  | waiting for loader to drop load_done (request accepted)
// S_WAIT_HIGH | waiting for loader to raise load_done (ROM valid)
module game_select_ctrl #(
  parameter int DEBOUNCE_CYCLES   = 16,
  parameter int LONG_PRESS_CYCLES = 64,
  parameter int NUM_GAMES         = 8,
  parameter int LOAD_TIMEOUT      = 1024
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      btn_n,
  game_select_ctrl_if.master        mem,
  output logic                      nes_hold,
  output logic                      busy,
  output logic                      load_error
);

  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HOLD_W = $clog2(LONG_PRESS_CYCLES + 1);
  localparam int TMO_W  = $clog2(LOAD_TIMEOUT + 1);

  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_PRESS_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_LONG = HOLD_W'(LONG_PRESS_CYCLES - 1);
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(LOAD_TIMEOUT - 1);
  localparam logic [3:0]        IDX_LAST  = 4'(NUM_GAMES - 1);

  typedef enum logic [2:0] {
    S_BOOT,
    S_IDLE,
    S_PRESSED,
    S_RELOAD,
    S_WAIT_LOW,
    S_WAIT_HIGH
  } state_t;

  logic              sync1_q, sync1_d;
  logic              sync2_q, sync2_d;
  logic              deb_q, deb_d;
  logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  state_t            state_q, state_d;
  logic [3:0]        index_q, index_d;
  logic              reload_q, reload_d;
  logic              nes_hold_q, nes_hold_d;
  logic              busy_q, busy_d;
  logic              load_error_q, load_error_d;

  logic              deb_flip;
  logic              press_evt;
  logic              release_evt;
  logic              long_press;
  logic              tmo_hit;
  logic              waiting;

  // Synchronizer and debouncer; a flip is reported the cycle it is accepted.
  always_comb begin
    sync1_d  = btn_n;
    sync2_d  = sync1_q;
    deb_d    = deb_q;
    db_cnt_d = '0;
    deb_flip = 1'b0;
    if (sync2_q != deb_q) begin
      if (db_cnt_q == DB_LAST) begin
        deb_d    = sync2_q;
        deb_flip = 1'b1;
      end else begin
        db_cnt_d = db_cnt_q + DB_W'(1);
      end
    end
    press_evt   = deb_flip & ~sync2_q;
    release_evt = deb_flip &  sync2_q;
  end

  // Next-state and registered-output logic for the sequencer.
  always_comb begin
    state_d      = state_q;
    index_d      = index_q;
    reload_d     = 1'b0;
    nes_hold_d   = nes_hold_q;
    load_error_d = load_error_q;
    hold_d       = hold_q;
    // A release on the cycle the hold count would saturate is long.
    long_press   = (hold_q >= HOLD_LONG);
    tmo_hit      = (tmo_q == TMO_LAST);

    case (state_q)
      S_BOOT: begin
        if (mem.load_done) begin
          state_d    = S_IDLE;
          nes_hold_d = 1'b0;
        end else if (tmo_hit) begin
          state_d      = S_IDLE;
          load_error_d = 1'b1;
        end
      end
      S_IDLE: begin
        if (press_evt) begin
          state_d = S_PRESSED;
          hold_d  = '0;
        end
      end
      S_PRESSED: begin
        if (release_evt) begin
          if (!long_press) begin
            index_d = (index_q == IDX_LAST) ? 4'd0 : index_q + 4'd1;
          end
          state_d    = S_RELOAD;
          reload_d   = 1'b1;
          nes_hold_d = 1'b1;
        end else if (hold_q != HOLD_MAX) begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      S_RELOAD: begin
        state_d = S_WAIT_LOW;
      end
      S_WAIT_LOW: begin
        if (!mem.load_done) begin
          state_d = S_WAIT_HIGH;
        end else if (tmo_hit) begin
          state_d      = S_IDLE;
          load_error_d = 1'b1;
        end
      end
      S_WAIT_HIGH: begin
        if (mem.load_done) begin
          state_d      = S_IDLE;
          nes_hold_d   = 1'b0;
          load_error_d = 1'b0;
        end else if (tmo_hit) begin
          state_d      = S_IDLE;
          load_error_d = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);

    // The load timer only runs while parked in a wait state.
    waiting = (state_q == S_BOOT) || (state_q == S_WAIT_LOW) ||
              (state_q == S_WAIT_HIGH);
    if ((state_d != state_q) || !waiting) begin
      tmo_d = '0;
    end else begin
      tmo_d = tmo_q + TMO_W'(1);
    end
  end

  // State and output registers; reset holds the NES and restarts the boot load.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q      <= 1'b1;
      sync2_q      <= 1'b1;
      deb_q        <= 1'b1;
      db_cnt_q     <= '0;
      hold_q       <= '0;
      tmo_q        <= '0;
      state_q      <= S_BOOT;
      index_q      <= 4'd0;
      reload_q     <= 1'b0;
      nes_hold_q   <= 1'b1;
      busy_q       <= 1'b1;
      load_error_q <= 1'b0;
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      deb_q        <= deb_d;
      db_cnt_q     <= db_cnt_d;
      hold_q       <= hold_d;
      tmo_q        <= tmo_d;
      state_q      <= state_d;
      index_q      <= index_d;
      reload_q     <= reload_d;
      nes_hold_q   <= nes_hold_d;
      busy_q       <= busy_d;
      load_error_q <= load_error_d;
    end
  end

  assign mem.index  = index_q;
  assign mem.reload = reload_q;
  assign nes_hold   = nes_hold_q;
  assign busy       = busy_q;
  assign load_error = load_error_q;

endmodule

// File: tb/tb_game_select_ctrl.sv
// Bench for game_select_ctrl: directed scenarios plus randomized presses
// against an event-level model of the game index and error flag.
module tb_game_select_ctrl;

  localparam int DEB  = 4;
  localparam int LONG = 20;
  localparam int NG   = 3;
  localparam int TMO  = 50;

  logic clock;
  logic reset_n;
  logic btn_n;
  logic nes_hold;
  logic busy;
  logic load_error;

  game_select_ctrl_if mem_if ();

  game_select_ctrl #(
    .DEBOUNCE_CYCLES   (DEB),
    .LONG_PRESS_CYCLES (LONG),
    .NUM_GAMES         (NG),
    .LOAD_TIMEOUT      (TMO)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .btn_n      (btn_n),
    .mem        (mem_if),
    .nes_hold   (nes_hold),
    .busy       (busy),
    .load_error (load_error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;
  int rl_cnt   = 0;
  int rl_idx   = -1;
  int idx_m    = 0;
  int err_m    = 0;

  // One comparison: counts it and reports a mismatch.
  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance to the next falling edge and record any reload pulse seen.
  task automatic tick();
    @(negedge clock);
    if (mem_if.reload) begin
      rl_cnt++;
      rl_idx = int'(mem_if.index);
    end
  endtask

  // One press of low_cyc raw cycles, followed by a loader that either
  // completes normally or leaves load_done stuck high.
  task automatic do_press(input int low_cyc, input bit stuck);
    int  t;
    int  exp_idx;
    bit  is_long;
    is_long = (low_cyc >= LONG);
    exp_idx = is_long ? idx_m : (idx_m + 1) % NG;
    rl_cnt  = 0;
    rl_idx  = -1;
    btn_n   = 1'b0;
    repeat (low_cyc) tick();
    btn_n = 1'b1;
    t = 0;
    while (rl_cnt == 0 && t < 60) begin
      tick();
      t++;
    end
    chk("release_latency", t, DEB + 2);
    chk("reload_index", rl_idx, exp_idx);
    chk("hold_at_reload", int'(nes_hold), 1);
    tick();
    chk("reload_one_cycle", int'(mem_if.reload), 0);
    if (!stuck) begin
      tick();
      mem_if.load_done = 1'b0;
      repeat (10) tick();
      chk("hold_during_load", int'(nes_hold), 1);
      mem_if.load_done = 1'b1;
      tick();
      chk("hold_released", int'(nes_hold), 0);
      chk("busy_after_load", int'(busy), 0);
      chk("error_after_load", int'(load_error), 0);
      err_m = 0;
    end else begin
      repeat (TMO - 1) tick();
      chk("busy_before_timeout", int'(busy), 1);
      tick();
      chk("busy_after_timeout", int'(busy), 0);
      chk("error_on_timeout", int'(load_error), 1);
      chk("hold_on_timeout", int'(nes_hold), 1);
      err_m = 1;
    end
    chk("reload_count", rl_cnt, 1);
    chk("index_after", int'(mem_if.index), exp_idx);
    idx_m = exp_idx;
    repeat (3) tick();
  endtask

  initial begin
    int t;
    int len;
    bit stk;
    reset_n          = 1'b0;
    btn_n            = 1'b1;
    mem_if.load_done = 1'b0;
    repeat (3) @(negedge clock);
    #1;
    chk("rst_index", int'(mem_if.index), 0);
    chk("rst_reload", int'(mem_if.reload), 0);
    chk("rst_nes_hold", int'(nes_hold), 1);
    chk("rst_busy", int'(busy), 1);
    chk("rst_error", int'(load_error), 0);

    // Boot: loader finishes 30 cycles after reset release.
    @(negedge clock);
    reset_n = 1'b1;
    repeat (29) tick();
    chk("boot_hold_waiting", int'(nes_hold), 1);
    chk("boot_busy_waiting", int'(busy), 1);
    mem_if.load_done = 1'b1;
    tick();
    chk("boot_hold_done", int'(nes_hold), 0);
    chk("boot_busy_done", int'(busy), 0);
    chk("boot_error", int'(load_error), 0);
    chk("boot_index", int'(mem_if.index), 0);
    repeat (3) tick();

    // Short presses walk the index 1, 2, 0, 1.
    for (int i = 0; i < 4; i++) do_press(10, 1'b0);

    // Bouncing button never settles long enough to count.
    rl_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      btn_n = ~btn_n;
      repeat (2) tick();
    end
    btn_n = 1'b1;
    repeat (20) tick();
    chk("bounce_reloads", rl_cnt, 0);
    chk("bounce_busy", int'(busy), 0);
    chk("bounce_index", int'(mem_if.index), idx_m);

    // Long presses, including the exact threshold, and one just below it.
    do_press(40, 1'b0);
    do_press(LONG, 1'b0);
    do_press(LONG - 1, 1'b0);

    // Timeout with load_done stuck high, then a clean load clears the error.
    do_press(10, 1'b1);
    chk("error_persists", int'(load_error), 1);
    do_press(10, 1'b0);

    // A press during WAIT_HIGH is ignored; reset mid-load restores defaults.
    rl_cnt = 0;
    btn_n  = 1'b0;
    repeat (30) tick();
    btn_n = 1'b1;
    t = 0;
    while (rl_cnt == 0 && t < 60) begin
      tick();
      t++;
    end
    chk("midload_reload_index", rl_idx, idx_m);
    tick();
    tick();
    mem_if.load_done = 1'b0;
    rl_cnt = 0;
    btn_n  = 1'b0;
    repeat (10) tick();
    btn_n = 1'b1;
    repeat (12) tick();
    chk("ignored_press_reloads", rl_cnt, 0);
    chk("ignored_press_busy", int'(busy), 1);
    chk("midload_index", int'(mem_if.index), idx_m);
    reset_n = 1'b0;
    #1;
    chk("midrst_index", int'(mem_if.index), 0);
    chk("midrst_reload", int'(mem_if.reload), 0);
    chk("midrst_nes_hold", int'(nes_hold), 1);
    chk("midrst_busy", int'(busy), 1);
    rl_cnt = 0;
    repeat (3) tick();
    chk("midrst_no_reload", rl_cnt, 0);
    reset_n = 1'b1;
    idx_m   = 0;
    err_m   = 0;
    repeat (5) tick();
    chk("reboot_busy", int'(busy), 1);
    mem_if.load_done = 1'b1;
    tick();
    chk("reboot_hold", int'(nes_hold), 0);
    repeat (3) tick();

    // Randomized presses with an occasionally stuck loader.
    for (int i = 0; i < 10; i++) begin
      len = $urandom_range(6, 40);
      stk = ($urandom_range(0, 3) == 0);
      chk("rand_error_before", int'(load_error), err_m);
      do_press(len, stk);
      btn_n = 1'b1;
      repeat (int'($urandom_range(1, 8))) tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Hard time limit so a stuck run still ends.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
